// File: rtl/padding_2d_if.sv
// Stream and configuration bundle for padding_2d.
// The slave side is the padder; the master side is the pixel source and the downstream sink.
interface padding_2d_if #(
    parameter int DATA_WIDTH = 16
);
    logic [1:0]            cfg_mode;
    logic [DATA_WIDTH-1:0] cfg_const;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sof;
    logic                  out_eol;
    logic                  out_eof;
    logic                  busy;

    modport master (
        output cfg_mode, cfg_const, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eol, out_eof, busy
    );

    modport slave (
        input  cfg_mode, cfg_const, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eol, out_eof, busy
    );
endinterface

// File: rtl/padding_2d.sv
// Four-sided streaming padder for a raster feature map.
// Zero, constant or column-replicate padding behind a single output register.
module padding_2d #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 634,
    parameter int HEIGHT     = 506,
    parameter int PAD_L      = 3,
    parameter int PAD_R      = 3,
    parameter int PAD_T      = 3,
    parameter int PAD_B      = 3
) (
    input logic         clk,
    input logic         rst_n,
    padding_2d_if.slave bus
);
    localparam int OW = PAD_L + WIDTH + PAD_R;
    localparam int OH = PAD_T + HEIGHT + PAD_B;
    localparam int CW = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW = (OH > 1) ? $clog2(OH) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(OW - 1);
    localparam logic [CW-1:0] COL_LEND = CW'(PAD_L - 1);
    localparam logic [CW-1:0] COL_BEND = CW'(PAD_L + WIDTH - 1);
    localparam logic [RW-1:0] ROW_TEND = RW'(PAD_T - 1);
    localparam logic [RW-1:0] ROW_AEND = RW'(PAD_T + HEIGHT - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OH - 1);

    typedef enum logic [2:0] {
        IDLE,
        TOP,
        LEFT,
        BODY,
        RIGHT,
        BOTTOM
    } state_t;

    localparam state_t ROW_ST   = (PAD_L > 0) ? LEFT : BODY;
    localparam state_t FIRST_ST = (PAD_T > 0) ? TOP : ROW_ST;

    state_t                state_q, state_d;
    logic [CW-1:0]         col_q, col_d;
    logic [RW-1:0]         row_q, row_d;
    logic [1:0]            mode_q, mode_d;
    logic [DATA_WIDTH-1:0] const_q, const_d;
    logic [DATA_WIDTH-1:0] pix_first_q, pix_first_d;
    logic [DATA_WIDTH-1:0] pix_last_q, pix_last_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  sof_q, sof_d;
    logic                  eol_q, eol_d;
    logic                  eof_q, eof_d;

    logic                  load;
    logic                  emit;
    logic                  start;
    logic                  in_ready;
    logic                  row_end;
    logic                  replicate;
    logic [DATA_WIDTH-1:0] pad_val;
    logic [DATA_WIDTH-1:0] side_val;
    logic [DATA_WIDTH-1:0] tb_val;

    assign load      = !out_valid_q || bus.out_ready;
    assign replicate = (mode_q == 2'd2);
    assign side_val  = (mode_q == 2'd1) ? const_q : '0;
    assign tb_val    = (mode_q == 2'd1) ? const_q : '0;

    // Sequencing of pad/body regions, counters and the output register load.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        mode_d      = mode_q;
        const_d     = const_q;
        pix_first_d = pix_first_q;
        pix_last_d  = pix_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sof_d       = sof_q;
        eol_d       = eol_q;
        eof_d       = eof_q;
        emit        = 1'b0;
        start       = 1'b0;
        in_ready    = 1'b0;
        row_end     = 1'b0;
        pad_val     = '0;

        unique case (state_q)
            IDLE: begin
                start = bus.in_valid;
            end
            TOP: begin
                emit    = load;
                pad_val = tb_val;
                if (emit && col_q == COL_LAST && row_q == ROW_TEND) begin
                    state_d = ROW_ST;
                end
            end
            LEFT: begin
                // Replicate mode peeks the row's first pixel, so it must be present.
                emit = load && (!replicate || bus.in_valid);
                if (replicate) begin
                    pad_val = (col_q == '0) ? bus.in_data : pix_first_q;
                end else begin
                    pad_val = side_val;
                end
                if (emit && col_q == '0) begin
                    pix_first_d = bus.in_data;
                end
                if (emit && col_q == COL_LEND) begin
                    state_d = BODY;
                end
            end
            BODY: begin
                in_ready = load;
                emit     = load && bus.in_valid;
                pad_val  = bus.in_data;
                if (emit) begin
                    pix_last_d = bus.in_data;
                end
                if (emit && col_q == COL_BEND) begin
                    if (PAD_R > 0) begin
                        state_d = RIGHT;
                    end else begin
                        row_end = 1'b1;
                    end
                end
            end
            RIGHT: begin
                emit    = load;
                pad_val = replicate ? pix_last_q : side_val;
                if (emit && col_q == COL_LAST) begin
                    row_end = 1'b1;
                end
            end
            BOTTOM: begin
                emit    = load;
                pad_val = tb_val;
                if (emit && col_q == COL_LAST && row_q == ROW_LAST) begin
                    state_d = IDLE;
                    start   = bus.in_valid;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (row_end) begin
            if (row_q != ROW_AEND) begin
                state_d = ROW_ST;
            end else if (PAD_B > 0) begin
                state_d = BOTTOM;
            end else begin
                state_d = IDLE;
                // The pixel on the bus is being consumed here; only restart
                // from a pad-only state where in_valid belongs to the next frame.
                start   = (state_q == RIGHT) && bus.in_valid;
            end
        end

        if (start) begin
            state_d = FIRST_ST;
            mode_d  = bus.cfg_mode;
            const_d = bus.cfg_const;
        end

        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = pad_val;
            sof_d       = (row_q == '0) && (col_q == '0);
            eol_d       = (col_q == COL_LAST);
            eof_d       = (row_q == ROW_LAST) && (col_q == COL_LAST);
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            sof_d       = 1'b0;
            eol_d       = 1'b0;
            eof_d       = 1'b0;
        end
    end

    // State, counters, frame config and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            mode_q      <= '0;
            const_q     <= '0;
            pix_first_q <= '0;
            pix_last_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sof_q       <= 1'b0;
            eol_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            pix_first_q <= pix_first_d;
            pix_last_q  <= pix_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sof_q       <= sof_d;
            eol_q       <= eol_d;
            eof_q       <= eof_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = sof_q;
    assign bus.out_eol   = eol_q;
    assign bus.out_eof   = eof_q;
    assign bus.busy      = (state_q != IDLE) || out_valid_q;
endmodule

// File: tb/tb_padding_2d.sv
// Directed bench for padding_2d: padded geometry and a zero-pad passthrough.
// Expected pixels come from a small padding model and hand-written rows.
module tb_padding_2d;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    padding_2d_if #(.DATA_WIDTH(DW)) a_if ();
    padding_2d_if #(.DATA_WIDTH(DW)) b_if ();

    padding_2d #(
        .DATA_WIDTH(DW), .WIDTH(4), .HEIGHT(3),
        .PAD_L(2), .PAD_R(1), .PAD_T(1), .PAD_B(2)
    ) u_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if)
    );

    padding_2d #(
        .DATA_WIDTH(DW), .WIDTH(4), .HEIGHT(3),
        .PAD_L(0), .PAD_R(0), .PAD_T(0), .PAD_B(0)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if)
    );

    logic [1:0]    cfg_mode = 2'd0;
    logic [DW-1:0] cfg_const = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          sel = 1'b0;

    assign a_if.cfg_mode  = cfg_mode;
    assign a_if.cfg_const = cfg_const;
    assign a_if.in_valid  = in_valid;
    assign a_if.in_data   = in_data;
    assign a_if.out_ready = out_ready;
    assign b_if.cfg_mode  = cfg_mode;
    assign b_if.cfg_const = cfg_const;
    assign b_if.in_valid  = in_valid;
    assign b_if.in_data   = in_data;
    assign b_if.out_ready = out_ready;

    logic          o_valid, o_rdy, o_sof, o_eol, o_eof, o_busy;
    logic [DW-1:0] o_data;
    assign o_valid = sel ? b_if.out_valid : a_if.out_valid;
    assign o_rdy   = sel ? b_if.in_ready  : a_if.in_ready;
    assign o_sof   = sel ? b_if.out_sof   : a_if.out_sof;
    assign o_eol   = sel ? b_if.out_eol   : a_if.out_eol;
    assign o_eof   = sel ? b_if.out_eof   : a_if.out_eof;
    assign o_busy  = sel ? b_if.busy      : a_if.busy;
    assign o_data  = sel ? b_if.out_data  : a_if.out_data;

    int n_chk = 0;
    int n_fail = 0;

    int g_l, g_r, g_t, g_b;
    int g_w = 4;
    int g_h = 3;

    logic [DW-1:0] got_d [0:511];
    logic [2:0]    got_m [0:511];
    int            n_got;
    logic [DW-1:0] fr_const [0:2];

    logic [DW-1:0] exp_r1 [0:6] = '{16'd0, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
    logic [DW-1:0] exp_r2 [0:6] = '{16'd5, 16'd5, 16'd5, 16'd6, 16'd7, 16'd8, 16'd8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model(input int mode, input logic [DW-1:0] k,
                                             input int base, input int r, input int c);
        int ir;
        int ic;
        ir = r - g_t;
        ic = c - g_l;
        if (ir < 0 || ir >= g_h) return (mode == 1) ? k : 16'h0;
        if (ic >= 0 && ic < g_w) return 16'(base + ir * g_w + ic + 1);
        if (mode == 1) return k;
        if (mode == 2) begin
            if (ic < 0) return 16'(base + ir * g_w + 1);
            return 16'(base + ir * g_w + g_w);
        end
        return 16'h0;
    endfunction

    function automatic logic [DW-1:0] src_val(input int idx);
        int n;
        n = g_w * g_h;
        return 16'((idx / n) * 100 + (idx % n) + 1);
    endfunction

    task automatic reset_dut();
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input int nfr, input int pv, input int pr,
                       input int gap_at, input int rst_at, input int chg_at);
        int ow, oh, nin, ntot, idx, gap_cnt;
        logic acc_in, acc_out, p_acc, p_stall;
        logic [DW-1:0] p_in, p_out;
        ow = g_l + g_w + g_r;
        oh = g_t + g_h + g_b;
        nin = nfr * g_w * g_h;
        ntot = nfr * ow * oh;
        idx = 0;
        n_got = 0;
        gap_cnt = (gap_at >= 0) ? 3 : 0;
        acc_in = 1'b0;
        p_acc = 1'b0;
        p_stall = 1'b0;
        p_in = '0;
        p_out = '0;
        in_valid = 1'b0;
        in_data = 16'hDEAD;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (n_got >= ntot) break;
            if (rst_at >= 0 && idx >= rst_at) break;
            @(posedge clk);
            #1;
            if (cyc == chg_at) cfg_const = 16'h1111;
            if (!in_valid || acc_in) begin
                if (idx == gap_at && gap_cnt > 0) begin
                    in_valid = 1'b0;
                    in_data = 16'hDEAD;
                    gap_cnt--;
                end else if (idx < nin && int'($urandom_range(99)) < pv) begin
                    in_valid = 1'b1;
                    in_data = src_val(idx);
                end else begin
                    in_valid = 1'b0;
                    in_data = 16'hDEAD;
                end
            end
            out_ready = (int'($urandom_range(99)) < pr);
            @(negedge clk);
            if (p_acc) begin
                check("latency_vld", 32'(o_valid), 32'd1);
                check("latency_dat", 32'(o_data), 32'(p_in));
            end
            if (p_stall) begin
                check("stall_vld", 32'(o_valid), 32'd1);
                check("stall_dat", 32'(o_data), 32'(p_out));
            end
            acc_in = in_valid && o_rdy;
            acc_out = o_valid && out_ready;
            if (acc_out && n_got < 512) begin
                got_d[n_got] = o_data;
                got_m[n_got] = {o_sof, o_eol, o_eof};
                n_got++;
            end
            if (acc_in) idx++;
            p_acc = acc_in;
            p_in = in_data;
            p_stall = o_valid && !out_ready;
            p_out = o_data;
        end
        if (rst_at < 0) begin
            in_valid = 1'b0;
            check("out_count", 32'(n_got), 32'(ntot));
            check("in_count", 32'(idx), 32'(nin));
        end
    endtask

    task automatic verify(input int nfr, input int mode);
        int ow, oh, k;
        logic [2:0] m;
        ow = g_l + g_w + g_r;
        oh = g_t + g_h + g_b;
        for (int f = 0; f < nfr; f++) begin
            for (int r = 0; r < oh; r++) begin
                for (int c = 0; c < ow; c++) begin
                    k = f * ow * oh + r * ow + c;
                    m = {r == 0 && c == 0, c == ow - 1, r == oh - 1 && c == ow - 1};
                    check("pix", 32'(got_d[k]), 32'(model(mode, fr_const[f], f * 100, r, c)));
                    check("mark", 32'(got_m[k]), 32'(m));
                end
            end
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_data", 32'(o_data), 32'd0);
        check("rst_sof", 32'(o_sof), 32'd0);
        check("rst_eol", 32'(o_eol), 32'd0);
        check("rst_eof", 32'(o_eof), 32'd0);
        check("rst_in_ready", 32'(o_rdy), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
    endtask

    task automatic geo_a();
        sel = 1'b0;
        g_l = 2; g_r = 1; g_t = 1; g_b = 2;
    endtask

    initial begin
        fr_const[0] = 16'hABCD;
        fr_const[1] = 16'h1111;
        fr_const[2] = 16'h0;
        geo_a();

        // reset state
        reset_dut();
        check_reset_outputs();

        // zero padding
        cfg_mode = 2'd0;
        run(1, 100, 100, -1, -1, -1);
        verify(1, 0);
        for (int c = 0; c < 7; c++) check("row1_zero", 32'(got_d[7 + c]), 32'(exp_r1[c]));
        check("sof_w0", 32'(got_m[0]), 32'b100);
        check("eol_w6", 32'(got_m[6]), 32'b010);
        check("eof_w41", 32'(got_m[41]), 32'b011);

        // constant padding, mid-frame config change lands on the next frame
        reset_dut();
        cfg_mode = 2'd1;
        cfg_const = 16'hABCD;
        run(2, 100, 100, -1, -1, 10);
        verify(2, 1);
        check("const_f1", 32'(got_d[0]), 32'hABCD);
        check("const_f2", 32'(got_d[42]), 32'h1111);

        // replicate padding with a source gap at the start of row 2
        reset_dut();
        cfg_mode = 2'd2;
        run(1, 100, 100, 4, -1, -1);
        verify(1, 2);
        for (int c = 0; c < 7; c++) check("row2_repl", 32'(got_d[14 + c]), 32'(exp_r2[c]));
        check("repl_top", 32'(got_d[3]), 32'd0);

        // random stalls on both sides over three frames
        reset_dut();
        cfg_mode = 2'd2;
        run(3, 70, 50, -1, -1, -1);
        verify(3, 2);

        // passthrough instance
        sel = 1'b1;
        g_l = 0; g_r = 0; g_t = 0; g_b = 0;
        reset_dut();
        cfg_mode = 2'd0;
        run(1, 100, 100, -1, -1, -1);
        verify(1, 0);
        check("pt_eol_w3", 32'(got_m[3]), 32'b010);
        check("pt_eol_w7", 32'(got_m[7]), 32'b010);
        check("pt_eof_w11", 32'(got_m[11]), 32'b011);

        // asynchronous reset in the middle of row 2
        geo_a();
        reset_dut();
        cfg_mode = 2'd0;
        run(1, 100, 100, -1, 6, -1);
        check("busy_pre_rst", 32'(o_busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run(1, 100, 100, -1, -1, -1);
        verify(1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/padding_2d.md
Name: padding_2d

Overview:
- Parametrised successor to the column-only padder: pads a streamed feature map on all four sides, left/right columns and top/bottom rows.
- Supports a run-time pad mode: zero, constant, or column-replicate.
- Uses a valid/ready handshake on both sides, so it tolerates stalls and needs no blanking gap.
- Sits between the pixel source (grayscale/Gaussian stage) and the NxN window/line-buffer stages of the Canny pipeline.

Parameters:
- DATA_WIDTH, 16, pixel width in bits
- WIDTH, 634, active columns per input row
- HEIGHT, 506, active rows per input frame
- PAD_L, 3, left pad columns (0 allowed)
- PAD_R, 3, right pad columns (0 allowed)
- PAD_T, 3, top pad rows (0 allowed)
- PAD_B, 3, bottom pad rows (0 allowed)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_mode  in  2  pad mode: 0 zero, 1 constant, 2 column-replicate, 3 reserved (treated as 0)
- cfg_const  in  DATA_WIDTH  constant pad value for mode 1
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  input pixel, raster order
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  DATA_WIDTH  padded pixel
- out_sof  out  1  first pixel of output frame
- out_eol  out  1  last pixel of each output row
- out_eof  out  1  last pixel of output frame
- busy  out  1  frame in progress (state != IDLE or out_valid)

Behaviour:
- Output frame size: (PAD_T+HEIGHT+PAD_B) rows x (PAD_L+WIDTH+PAD_R) cols. Exactly WIDTH*HEIGHT inputs are consumed per frame.
- Counters: col_cnt and row_cnt, each $clog2 of padded extent; pix_first/pix_last registers.
- FSM states:
  - IDLE: wait for in_valid; latch cfg_mode and cfg_const into frame registers. Config changes mid-frame are ignored. Go to TOP if PAD_T>0, else LEFT.
  - TOP: emit PAD_T full padded rows → LEFT.
  - LEFT: emit PAD_L pixels → BODY. If PAD_L=0, go directly to BODY.
  - BODY: pass WIDTH input pixels → RIGHT, or → next row when PAD_R=0.
  - RIGHT: emit PAD_R pixels. After the last active row go to BOTTOM, or IDLE if PAD_B=0; otherwise go to LEFT.
  - BOTTOM: emit PAD_B rows → IDLE.
- Pad value:
  - Mode 0: 0.
  - Mode 1: latched const, all four sides.
  - Mode 2, left columns: current row's first pixel, peeked from in_data without consuming; LEFT stalls (no emission) until in_valid=1.
  - Mode 2, right columns: last accepted pixel of that row (pix_last).
  - Mode 2, top/bottom rows: 0.
- Output register: a single stage. It loads when !out_valid || out_ready, and out_* hold stable while out_valid && !out_ready.
- in_ready = (state==BODY) && (!out_valid || out_ready). It is combinational from state and out_ready; it never depends on in_valid.
- Latency: an accepted input pixel appears on out_data the next cycle. Pad pixels are emitted one per cycle with no bubbles while out_ready=1.
- Markers:
  - out_sof: row_cnt=0, col_cnt=0.
  - out_eol: col_cnt = last column.
  - out_eof: last row and last column.
- All markers are qualified with out_valid.
- Back-to-back frames: IDLE→next frame with zero idle cycles if in_valid is already high when the previous out_eof is accepted.
- Reset values: out_valid=0, out_data=0, out_sof=0, out_eol=0, out_eof=0, in_ready=0, busy=0; state=IDLE; counters=0.
- Reset asserted mid-frame aborts the frame immediately with no partial flush.
- Counters wrap to 0 at row/frame end, never beyond their terminal counts. Terminal compares use full padded extents.

Test Plan:
- WIDTH=4, HEIGHT=3, PAD_L=2, PAD_R=1, PAD_T=1, PAD_B=2, mode 0, inputs 1..12, out_ready=1 → 6 rows x 7 cols. Row 1 = 0,0,1,2,3,4,0. out_sof on the first word, out_eol every 7th word, out_eof on word 42. 12 inputs consumed.
- Same geometry, mode 1, cfg_const=0xABCD → every non-image pixel = 0xABCD. Changing cfg_const mid-frame to 0x1111 has no effect until the next frame.
- Mode 2, row inputs 5,6,7,8 → output row 5,5,5,6,7,8,8. Top/bottom rows all 0. With in_valid deasserted for 3 cycles at the start of LEFT, no left pad is emitted until the pixel arrives.
- Random out_ready (50%) and in_valid (70%) over 3 consecutive frames → output stream identical to the no-stall reference. out_data stable under stall, no lost or duplicated pixels, in_ready never high outside BODY.
- PAD_L=PAD_R=PAD_T=PAD_B=0 → pure passthrough with 1-cycle latency. out_eol every 4 words; out_eof on word 12.
- rst_n pulsed low mid-BODY of row 2 → all outputs 0 asynchronously. After release, the next frame starts cleanly with out_sof on the first output.
